// File: rtl/circle_list_regfile_n_if.sv
// Bus bundle for circle_list_regfile_n: write/pointer controls, search handshake,
// ring chaining tokens and the observed pointer/data outputs.
interface circle_list_regfile_n_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             line_pointer_rst;
    logic             line_pointer_set;
    logic [AW-1:0]    ptr_set_val;
    logic             clear_all;
    logic             srch_start;
    logic [WIDTH-1:0] srch_key;
    logic             next_in;
    logic             get_in;
    logic             get_out;
    logic             next_out;
    logic             busy;
    logic             transmigration;
    logic [AW-1:0]    line_pointer_addr;
    logic [WIDTH-1:0] cur_data;

    modport master (
        output wr_en, wr_data, line_pointer_rst, line_pointer_set, ptr_set_val,
               clear_all, srch_start, srch_key, next_in, get_in,
        input  get_out, next_out, busy, transmigration, line_pointer_addr, cur_data
    );

    modport slave (
        input  wr_en, wr_data, line_pointer_rst, line_pointer_set, ptr_set_val,
               clear_all, srch_start, srch_key, next_in, get_in,
        output get_out, next_out, busy, transmigration, line_pointer_addr, cur_data
    );
endinterface

// File: rtl/circle_list_regfile_n.sv
// Circular register list with a wrapping line pointer and a one-entry-per-clock ring search
// that can be chained across instances through next/get tokens.
module circle_list_regfile_n #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    circle_list_regfile_n_if.slave bus
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    ptr, ptr_inc, lap;
    logic [WIDTH-1:0] key;
    logic             get_q, next_q, trans_q;

    logic free, start, set_ok, do_set, do_write, hit, step, lap_end, wrap;

    // NOTE: state is only ever updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.line_pointer_rst || bus.clear_all || bus.get_in) state_nxt = IDLE;
        else if (start)                                          state_nxt = SEARCH;
        else if (hit || lap_end)                                 state_nxt = IDLE;
    end

    // NOTE: every signal gets a value on every path here, so no latch can be inferred.
    always_comb begin
        free     = !bus.line_pointer_rst && !bus.clear_all && !bus.get_in;
        start    = free && (state == IDLE) && (bus.srch_start || bus.next_in);
        set_ok   = bus.ptr_set_val <= LAST;
        do_set   = free && (state == IDLE) && !(bus.srch_start || bus.next_in)
                   && bus.line_pointer_set && set_ok;
        do_write = free && (state == IDLE) && !(bus.srch_start || bus.next_in)
                   && !bus.line_pointer_set && bus.wr_en;
        hit      = free && (state == SEARCH) && valid[ptr] && (mem[ptr] == key);
        step     = free && (state == SEARCH) && !hit;
        lap_end  = step && (lap == LAST);
        // Modulo DEPTH explicitly: DEPTH need not be a power of two.
        ptr_inc  = (ptr == LAST) ? '0 : ptr + 1'b1;
        wrap     = (do_write || step) && (ptr == LAST);
    end

    assign bus.busy              = (state == SEARCH);
    assign bus.get_out           = get_q;
    assign bus.next_out          = next_q;
    assign bus.transmigration    = trans_q;
    assign bus.line_pointer_addr = ptr;
    assign bus.cur_data          = valid[ptr] ? mem[ptr] : '0;

    // NOTE: the entries live in resettable flops, not a RAM, because reset must zero every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_write) begin
            mem[ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            valid   <= '0;
            key     <= '0;
            lap     <= '0;
            get_q   <= 1'b0;
            next_q  <= 1'b0;
            trans_q <= 1'b0;
        end else begin
            get_q   <= hit;
            next_q  <= lap_end;
            trans_q <= wrap;

            if (bus.line_pointer_rst)     ptr <= '0;
            else if (do_set)              ptr <= bus.ptr_set_val;
            else if (do_write || step)    ptr <= ptr_inc;

            // clear_all only drops the flags; data words and pointer are left alone.
            if (bus.clear_all && !bus.line_pointer_rst) valid      <= '0;
            else if (do_write)                          valid[ptr] <= 1'b1;

            if (start) begin
                key <= bus.srch_key;
                lap <= '0;
            end else if (step) begin
                lap <= lap + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_circle_list_regfile_n.sv
// Self-checking bench: directed table, hand-written search/abort/chain sequences, a DEPTH=5
// instance, and randomized traffic checked against a search-level reference model.
module tb_circle_list_regfile_n;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic a_get_tb;
    logic link_en;

    always #5 clk = ~clk;

    circle_list_regfile_n_if #(.WIDTH(8), .AW(4)) bus_a ();
    circle_list_regfile_n_if #(.WIDTH(8), .AW(4)) bus_b ();
    circle_list_regfile_n_if #(.WIDTH(8), .AW(3)) bus_c ();

    assign bus_a.get_in  = a_get_tb | (link_en & bus_b.get_out);
    assign bus_b.next_in = link_en & bus_a.next_out;
    assign bus_b.get_in  = 1'b0;

    circle_list_regfile_n #(.WIDTH(8), .DEPTH(16), .AW(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    circle_list_regfile_n #(.WIDTH(8), .DEPTH(16), .AW(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    circle_list_regfile_n #(.WIDTH(8), .DEPTH(5),  .AW(3)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    typedef enum logic [1:0] {OP_WR, OP_SET, OP_NOP} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] val;
        logic [3:0] exp_ptr;
        logic [7:0] exp_cur;
        logic       exp_trans;
    } vec_t;
    vec_t vecs [18];

    // Search-level reference model of instance A.
    logic [7:0] m_mem [D];
    bit         m_val [D];
    int         m_ptr;

    function automatic logic [7:0] m_cur();
        return m_val[m_ptr] ? m_mem[m_ptr] : 8'h00;
    endfunction

    task automatic run_search(input logic [7:0] key, input int abort_at, input bit noise,
                              output int get_c, output int nxt_c, output int tcnt,
                              output int both, output int busy_n);
        int lim;
        get_c = -1; nxt_c = -1; tcnt = 0; both = 0; busy_n = 0;
        lim = (abort_at > 0) ? abort_at + 1 : D + 4;
        bus_a.srch_key   = key;
        bus_a.srch_start = 1'b1;
        for (int c = 1; c <= lim; c++) begin
            step();
            bus_a.srch_start       = 1'b0;
            bus_a.wr_en            = 1'b0;
            bus_a.line_pointer_set = 1'b0;
            a_get_tb               = (c == abort_at);
            if (bus_a.busy) busy_n++;
            if (bus_a.transmigration) tcnt++;
            if (bus_a.get_out && bus_a.next_out) both++;
            if (bus_a.get_out && get_c < 0) get_c = c;
            if (bus_a.next_out && nxt_c < 0) nxt_c = c;
            if (get_c >= 0 || nxt_c >= 0) break;
            if (noise && abort_at == 0) begin
                bus_a.wr_en            = 1'($urandom_range(0, 1));
                bus_a.wr_data          = 8'($urandom);
                bus_a.line_pointer_set = 1'($urandom_range(0, 1));
                bus_a.ptr_set_val      = 4'($urandom);
            end
        end
        a_get_tb               = 1'b0;
        bus_a.wr_en            = 1'b0;
        bus_a.line_pointer_set = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, n, t, b, bz, k, p0, r;
        logic [7:0] key, d;

        {bus_a.wr_en, bus_a.wr_data, bus_a.line_pointer_rst, bus_a.line_pointer_set,
         bus_a.ptr_set_val, bus_a.clear_all, bus_a.srch_start, bus_a.srch_key, bus_a.next_in} = '0;
        {bus_b.wr_en, bus_b.wr_data, bus_b.line_pointer_rst, bus_b.line_pointer_set,
         bus_b.ptr_set_val, bus_b.clear_all, bus_b.srch_start, bus_b.srch_key} = '0;
        {bus_c.wr_en, bus_c.wr_data, bus_c.line_pointer_rst, bus_c.line_pointer_set,
         bus_c.ptr_set_val, bus_c.clear_all, bus_c.srch_start, bus_c.srch_key,
         bus_c.next_in, bus_c.get_in} = '0;
        a_get_tb = 1'b0;
        link_en  = 1'b0;
        rst_n    = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_ptr",   32'(bus_a.line_pointer_addr), 0);
        check("rst_cur",   32'(bus_a.cur_data), 0);
        check("rst_busy",  32'(bus_a.busy), 0);
        check("rst_get",   32'(bus_a.get_out), 0);
        check("rst_next",  32'(bus_a.next_out), 0);
        check("rst_trans", 32'(bus_a.transmigration), 0);

        // Table: 16 writes 0x10..0x1F, one idle cycle, then pointer load 5
        for (int i = 0; i < 16; i++) begin
            vecs[i].op        = OP_WR;
            vecs[i].val       = 8'(8'h10 + i);
            vecs[i].exp_ptr   = 4'((i + 1) % 16);
            vecs[i].exp_cur   = (i == 15) ? 8'h10 : 8'h00;
            vecs[i].exp_trans = (i == 15);
        end
        vecs[16].op = OP_NOP; vecs[16].val = 8'h00; vecs[16].exp_ptr = 4'd0;
        vecs[16].exp_cur = 8'h10; vecs[16].exp_trans = 1'b0;
        vecs[17].op = OP_SET; vecs[17].val = 8'h05; vecs[17].exp_ptr = 4'd5;
        vecs[17].exp_cur = 8'h15; vecs[17].exp_trans = 1'b0;

        for (int i = 0; i < 18; i++) begin
            case (vecs[i].op)
                OP_WR:  begin bus_a.wr_data = vecs[i].val; bus_a.wr_en = 1'b1; end
                OP_SET: begin bus_a.ptr_set_val = vecs[i].val[3:0]; bus_a.line_pointer_set = 1'b1; end
                default: ;
            endcase
            step();
            bus_a.wr_en = 1'b0;
            bus_a.line_pointer_set = 1'b0;
            check($sformatf("vec%0d_ptr", i),   32'(bus_a.line_pointer_addr), 32'(vecs[i].exp_ptr));
            check($sformatf("vec%0d_cur", i),   32'(bus_a.cur_data),          32'(vecs[i].exp_cur));
            check($sformatf("vec%0d_trans", i), 32'(bus_a.transmigration),    32'(vecs[i].exp_trans));
        end

        // Hit at offset 14 from pointer 5
        run_search(8'h13, 0, 1'b0, g, n, t, b, bz);
        check("hit_get_cycle", 32'(g), 16);
        check("hit_next",      32'(n), 32'(-1));
        check("hit_ptr",       32'(bus_a.line_pointer_addr), 3);
        check("hit_cur",       32'(bus_a.cur_data), 32'h13);
        check("hit_trans",     32'(t), 1);
        check("hit_busy_n",    32'(bz), 15);

        // Full-lap miss from pointer 3
        run_search(8'hAA, 0, 1'b0, g, n, t, b, bz);
        check("miss_next_cycle", 32'(n), 17);
        check("miss_get",        32'(g), 32'(-1));
        check("miss_ptr",        32'(bus_a.line_pointer_addr), 3);
        check("miss_trans",      32'(t), 1);
        check("miss_busy_n",     32'(bz), 16);

        // Abort by get_in in cycle 4
        run_search(8'hAA, 4, 1'b0, g, n, t, b, bz);
        check("abort_get",    32'(g), 32'(-1));
        check("abort_next",   32'(n), 32'(-1));
        check("abort_busy",   32'(bus_a.busy), 0);
        check("abort_busy_n", 32'(bz), 4);
        check("abort_ptr",    32'(bus_a.line_pointer_addr), 6);

        // Asynchronous reset in the middle of a search
        bus_a.srch_key = 8'hAA; bus_a.srch_start = 1'b1;
        step(); bus_a.srch_start = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        check("rrst_busy",  32'(bus_a.busy), 0);
        check("rrst_ptr",   32'(bus_a.line_pointer_addr), 0);
        check("rrst_cur",   32'(bus_a.cur_data), 0);
        check("rrst_pulse", 32'({bus_a.get_out, bus_a.next_out, bus_a.transmigration}), 0);
        rst_n = 1'b1;
        bus_a.ptr_set_val = 4'd3; bus_a.line_pointer_set = 1'b1;
        step(); bus_a.line_pointer_set = 1'b0;
        check("rrst_valid3", 32'(bus_a.cur_data), 0);

        // Two chained instances: key only in B slot 2
        for (int i = 0; i < 3; i++) begin
            bus_b.wr_data = (i == 2) ? 8'h77 : 8'(i + 1);
            bus_b.wr_en = 1'b1;
            step();
        end
        bus_b.wr_en = 1'b0;
        bus_b.ptr_set_val = 4'd0; bus_b.line_pointer_set = 1'b1;
        step(); bus_b.line_pointer_set = 1'b0;
        link_en = 1'b1;
        bus_a.srch_key = 8'h77; bus_b.srch_key = 8'h77; bus_a.srch_start = 1'b1;
        g = -1; n = -1; b = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            bus_a.srch_start = 1'b0;
            if (bus_a.next_out && n < 0) n = c;
            if (bus_a.get_out || bus_b.next_out) b++;
            if (bus_b.get_out && g < 0) begin g = c; break; end
        end
        link_en = 1'b0;
        check("chain_a_next", 32'(n), 17);
        check("chain_b_get",  32'(g), 21);
        check("chain_b_ptr",  32'(bus_b.line_pointer_addr), 2);
        check("chain_other",  32'(b), 0);

        // DEPTH=5 instance: wrap after the 5th write, out-of-range pointer load ignored
        for (int i = 0; i < 6; i++) begin
            bus_c.wr_data = 8'(8'h40 + i); bus_c.wr_en = 1'b1;
            step(); bus_c.wr_en = 1'b0;
            check($sformatf("d5_wr%0d_trans", i), 32'(bus_c.transmigration), 32'(i == 4));
        end
        check("d5_ptr", 32'(bus_c.line_pointer_addr), 1);
        check("d5_cur", 32'(bus_c.cur_data), 32'h41);
        bus_c.ptr_set_val = 3'd7; bus_c.line_pointer_set = 1'b1;
        step(); bus_c.line_pointer_set = 1'b0;
        check("d5_set7_ignored", 32'(bus_c.line_pointer_addr), 1);
        bus_c.ptr_set_val = 3'd4; bus_c.line_pointer_set = 1'b1;
        step(); bus_c.line_pointer_set = 1'b0;
        check("d5_set4_ptr", 32'(bus_c.line_pointer_addr), 4);
        check("d5_set4_cur", 32'(bus_c.cur_data), 32'h44);

        // Randomized traffic on A against the reference model
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        for (int i = 0; i < D; i++) begin m_mem[i] = 8'h00; m_val[i] = 1'b0; end
        m_ptr = 0;
        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 10));
            if (r <= 4) begin
                d = 8'(8'h30 + $urandom_range(0, 7));
                bus_a.wr_data = d; bus_a.wr_en = 1'b1;
                step(); bus_a.wr_en = 1'b0;
                check("rnd_wr_trans", 32'(bus_a.transmigration), 32'(m_ptr == D - 1));
                m_mem[m_ptr] = d; m_val[m_ptr] = 1'b1;
                m_ptr = (m_ptr + 1) % D;
            end else if (r == 5) begin
                k = int'($urandom_range(0, D - 1));
                bus_a.ptr_set_val = 4'(k); bus_a.line_pointer_set = 1'b1;
                step(); bus_a.line_pointer_set = 1'b0;
                check("rnd_set_trans", 32'(bus_a.transmigration), 0);
                m_ptr = k;
            end else if (r == 6) begin
                bus_a.clear_all = 1'b1;
                step(); bus_a.clear_all = 1'b0;
                for (int i = 0; i < D; i++) m_val[i] = 1'b0;
            end else begin
                key = 8'(8'h30 + $urandom_range(0, 8));
                p0 = m_ptr; k = -1;
                for (int i = 0; i < D; i++) begin
                    if (m_val[(p0 + i) % D] && m_mem[(p0 + i) % D] == key) begin k = i; break; end
                end
                run_search(key, 0, 1'b1, g, n, t, b, bz);
                if (k >= 0) begin
                    m_ptr = (p0 + k) % D;
                    check("rnd_hit_cycle", 32'(g), 32'(k + 2));
                    check("rnd_hit_next",  32'(n), 32'(-1));
                    check("rnd_hit_trans", 32'(t), 32'((p0 + k >= D) ? 1 : 0));
                    check("rnd_hit_busy",  32'(bz), 32'(k + 1));
                end else begin
                    check("rnd_miss_cycle", 32'(n), 32'(D + 1));
                    check("rnd_miss_get",   32'(g), 32'(-1));
                    check("rnd_miss_trans", 32'(t), 1);
                    check("rnd_miss_busy",  32'(bz), 32'(D));
                end
                check("rnd_both", 32'(b), 0);
            end
            check("rnd_ptr", 32'(bus_a.line_pointer_addr), 32'(m_ptr));
            check("rnd_cur", 32'(bus_a.cur_data), 32'(m_cur()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
